// File: rtl/time_set_entry_pkg.sv
// Shared constants for the time-set entry block: mode code, digit indices,
// FSM encoding and the fixed per-digit BCD limits.
package time_set_entry_pkg;

  localparam logic [3:0] SET_MODE_DEFAULT = 4'd2;

  localparam logic [2:0] DIG_NONE = 3'd0;
  localparam logic [2:0] DIG_SU   = 3'd1;
  localparam logic [2:0] DIG_ST   = 3'd2;
  localparam logic [2:0] DIG_MU   = 3'd3;
  localparam logic [2:0] DIG_MT   = 3'd4;
  localparam logic [2:0] DIG_HU   = 3'd5;
  localparam logic [2:0] DIG_HT   = 3'd6;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EDIT   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  localparam logic [3:0] LIM_TENS  = 4'd5;
  localparam logic [3:0] LIM_UNITS = 4'd9;

  // Edit pointer walks from hour tens down to seconds units, then wraps.
  function automatic logic [2:0] nextDigitSel(input logic [2:0] sel);
    return (sel == DIG_SU) ? DIG_HT : sel - 3'd1;
  endfunction

endpackage

// File: rtl/time_set_entry_digit_step.sv
// One-digit BCD increment with wrap-to-zero at a caller-supplied limit.
// Digits already above the limit (illegal seeds) also wrap to zero.
module bcd_digit_step (
  input  logic [3:0] digit,
  input  logic [3:0] limit,
  output logic [3:0] nextDigit
);

  assign nextDigit = (digit >= limit) ? 4'd0 : digit + 4'd1;

endmodule

// File: rtl/time_set_entry.sv
// User time-entry writer: edits a BCD HH:MM:SS word while in set mode and
// strobes it into the clock counter on commit.
module time_set_entry
  import time_set_entry_pkg::*;
#(
  parameter int         HOUR_MAX = 23,
  parameter logic [3:0] SET_MODE = SET_MODE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  state,
  input  logic        incButton,
  input  logic        nextButton,
  input  logic        loadButton,
  input  logic [23:0] currentBits,
  output logic [23:0] clockBitsIn,
  output logic [2:0]  digitSel,
  output logic        loadPulse
);

  localparam logic [3:0] HOUR_TENS_LIM  = 4'(HOUR_MAX / 10);
  localparam logic [3:0] HOUR_UNITS_LIM = 4'(HOUR_MAX % 10);

  logic [1:0]  fsmState;
  logic        prevSetMode;
  logic        inSetMode;
  logic        modeEntry;
  logic [3:0]  selDigit;
  logic [3:0]  selLimit;
  logic [3:0]  stepDigit;
  logic [23:0] incBits;

  assign inSetMode = (state == SET_MODE);
  assign modeEntry = inSetMode && !prevSetMode;

  // Hour-units limit depends on whether hour tens is already at its maximum.
  always_comb begin
    selDigit = 4'd0;
    selLimit = LIM_UNITS;
    case (digitSel)
      DIG_HT: begin
        selDigit = clockBitsIn[23:20];
        selLimit = HOUR_TENS_LIM;
      end
      DIG_HU: begin
        selDigit = clockBitsIn[19:16];
        selLimit = (clockBitsIn[23:20] == HOUR_TENS_LIM) ? HOUR_UNITS_LIM : LIM_UNITS;
      end
      DIG_MT: begin
        selDigit = clockBitsIn[15:12];
        selLimit = LIM_TENS;
      end
      DIG_MU: selDigit = clockBitsIn[11:8];
      DIG_ST: begin
        selDigit = clockBitsIn[7:4];
        selLimit = LIM_TENS;
      end
      DIG_SU: selDigit = clockBitsIn[3:0];
      default: ;
    endcase
  end

  bcd_digit_step uStep (
    .digit     (selDigit),
    .limit     (selLimit),
    .nextDigit (stepDigit)
  );

  // Raising hour tens to its limit may push the hour past HOUR_MAX; clamp units.
  always_comb begin
    incBits = clockBitsIn;
    case (digitSel)
      DIG_HT: begin
        incBits[23:20] = stepDigit;
        if ((stepDigit == HOUR_TENS_LIM) && (clockBitsIn[19:16] > HOUR_UNITS_LIM))
          incBits[19:16] = HOUR_UNITS_LIM;
      end
      DIG_HU: incBits[19:16] = stepDigit;
      DIG_MT: incBits[15:12] = stepDigit;
      DIG_MU: incBits[11:8]  = stepDigit;
      DIG_ST: incBits[7:4]   = stepDigit;
      DIG_SU: incBits[3:0]   = stepDigit;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsmState    <= ST_IDLE;
      prevSetMode <= 1'b0;
      clockBitsIn <= 24'h000000;
      digitSel    <= DIG_NONE;
      loadPulse   <= 1'b0;
    end else begin
      prevSetMode <= inSetMode;
      loadPulse   <= 1'b0;
      case (fsmState)
        ST_IDLE: begin
          clockBitsIn <= currentBits;
          digitSel    <= DIG_NONE;
          if (modeEntry) begin
            fsmState <= ST_EDIT;
            digitSel <= DIG_HT;
          end
        end
        ST_EDIT: begin
          if (!inSetMode) begin
            fsmState <= ST_IDLE;
            digitSel <= DIG_NONE;
          end else if (loadButton) begin
            fsmState  <= ST_COMMIT;
            loadPulse <= 1'b1;
            digitSel  <= DIG_NONE;
          end else begin
            if (incButton)
              clockBitsIn <= incBits;
            if (nextButton)
              digitSel <= nextDigitSel(digitSel);
          end
        end
        ST_COMMIT: fsmState <= ST_IDLE;
        default:   fsmState <= ST_IDLE;
      endcase
    end
  end

endmodule
